// File: rtl/dmem_arbiter.sv
// Two-port (A: CPU, B: DMA/debug) data-memory arbiter; IDLE -> ACCESS -> RESP per transaction.
// Define DMEM_ARB_FIXED_PRIO_EN to make port A always win a tie instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_w_en,
  output logic          mem_en,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_gnt_b, w_gnt_b_nxt;
  logic          w_pick_b;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic          r_mem_w_en, w_mem_w_en_nxt;
  logic          r_mem_en, w_mem_en_nxt;
  logic          r_a_ack, w_a_ack_nxt;
  logic          r_b_ack, w_b_ack_nxt;
  logic [DW-1:0] r_a_rdata, w_a_rdata_nxt;
  logic [DW-1:0] r_b_rdata, w_b_rdata_nxt;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_pick_b = b_req & ~a_req;
`else
  logic r_last_b, w_last_b_nxt;

  // On a tie, B wins only if A was granted last
  assign w_pick_b = b_req & (~a_req | ~r_last_b);
`endif

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_b_nxt     = r_gnt_b;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_w_en_nxt  = r_mem_w_en;
    w_mem_en_nxt    = r_mem_en;
    w_a_ack_nxt     = 1'b0;
    w_b_ack_nxt     = 1'b0;
    w_a_rdata_nxt   = r_a_rdata;
    w_b_rdata_nxt   = r_b_rdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    w_last_b_nxt    = r_last_b;
`endif
    case (r_state)
      IDLE: begin
        if (a_req || b_req) begin
          w_state_nxt     = ACCESS;
          w_gnt_b_nxt     = w_pick_b;
          w_mem_addr_nxt  = w_pick_b ? b_addr  : a_addr;
          w_mem_wdata_nxt = w_pick_b ? b_wdata : a_wdata;
          w_mem_w_en_nxt  = w_pick_b ? b_we    : a_we;
          w_mem_en_nxt    = 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          w_last_b_nxt    = w_pick_b;
`endif
        end
      end
      ACCESS: begin
        w_state_nxt    = RESP;
        w_mem_en_nxt   = 1'b0;
        w_mem_w_en_nxt = 1'b0;
        w_a_ack_nxt    = ~r_gnt_b;
        w_b_ack_nxt    = r_gnt_b;
        if (!r_mem_w_en) begin
          if (r_gnt_b) w_b_rdata_nxt = mem_rdata;
          else         w_a_rdata_nxt = mem_rdata;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt_b     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_w_en  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_last_b    <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_b     <= w_gnt_b_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_w_en  <= w_mem_w_en_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_a_ack     <= w_a_ack_nxt;
      r_b_ack     <= w_b_ack_nxt;
      r_a_rdata   <= w_a_rdata_nxt;
      r_b_rdata   <= w_b_rdata_nxt;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      r_last_b    <= w_last_b_nxt;
`endif
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_w_en  = r_mem_w_en;
  assign mem_en    = r_mem_en;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grant order,
// ack cycle and read data; a negedge monitor pops and compares on every ack / access.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic          port_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_w_en, mem_en;
  logic [DW-1:0] mem_rdata;

  exp_t          sb[$];
  txn_t          qa[$], qb[$];
  bit [DW-1:0]   tb_mem[256];
  bit [DW-1:0]   m_mem[256];
  logic [DW-1:0] m_rdata[2];
  bit            m_last_b;
  int            cyc;
  int            errs;
  int            chks;
  exp_t          mon_e;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
    .mem_en(mem_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory attached to the arbiter
  always @(posedge clk) if (mem_en && mem_w_en) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ack || b_ack) check("ack_excl", 32'(a_ack & b_ack), 32'd0);
      if (mem_w_en) check("wen_needs_en", 32'(mem_en), 32'd1);
      if (a_ack || b_ack) begin
        if (sb.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b at cycle %0d", a_ack, b_ack, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("ack_port", 32'(b_ack), 32'(mon_e.port_b));
          check("rdata", 32'(b_ack ? b_rdata : a_rdata), 32'(mon_e.rdata));
          check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
        end
      end
      if (mem_en && sb.size() != 0) begin
        check("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
        check("mem_w_en", 32'(mem_w_en), 32'(sb[0].we));
        if (sb[0].we) check("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
        check("access_cycle", 32'(cyc), 32'(sb[0].ack_cyc - 1));
      end
    end
  end

  // Predicts the whole batch from the arbitration rules, then drives it; each port
  // keeps its req high and loads its next transaction in its ack cycle.
  task automatic run_batch(input bit poke);
    int   ia = 0, ib = 0, k = 0, c0, na, nb, left_a, left_b, guard;
    bit   pick_b;
    txn_t t;
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    na = qa.size();
    nb = qb.size();
    while (ia < na || ib < nb) begin
      if (ia < na && ib < nb) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick_b = 1'b0;
`else
        pick_b = !m_last_b;
`endif
      end else begin
        pick_b = (ib < nb);
      end
      t = pick_b ? qb[ib] : qa[ia];
      if (pick_b) ib++;
      else ia++;
      m_last_b = pick_b;
      if (t.we) m_mem[t.addr] = t.wdata;
      else      m_rdata[pick_b] = m_mem[t.addr];
      e.port_b  = pick_b;
      e.we      = t.we;
      e.addr    = t.addr;
      e.wdata   = t.wdata;
      e.rdata   = m_rdata[pick_b];
      e.ack_cyc = c0 + 2 + 3 * k;
      k++;
      sb.push_back(e);
    end
    ia = 0;
    ib = 0;
    if (na > 0) begin {a_we, a_addr, a_wdata} = qa[0]; a_req = 1'b1; ia = 1; end
    if (nb > 0) begin {b_we, b_addr, b_wdata} = qb[0]; b_req = 1'b1; ib = 1; end
    left_a = na;
    left_b = nb;
    guard  = 0;
    while ((left_a > 0 || left_b > 0) && guard < 3 * (na + nb) + 8) begin
      @(negedge clk);
      guard++;
      if (poke && guard == 1) a_addr = 8'd3;
      if (a_ack) begin
        left_a--;
        if (ia < na) begin {a_we, a_addr, a_wdata} = qa[ia]; ia++; end
        else a_req = 1'b0;
      end
      if (b_ack) begin
        left_b--;
        if (ib < nb) begin {b_we, b_addr, b_wdata} = qb[ib]; ib++; end
        else b_req = 1'b0;
      end
    end
    if (left_a > 0 || left_b > 0) begin
      chks++;
      errs++;
      $display("FAIL batch_timeout: acks missing a=%0d b=%0d at cycle %0d", left_a, left_b, cyc);
      a_req = 1'b0;
      b_req = 1'b0;
    end
    qa.delete();
    qb.delete();
  endtask

  function automatic txn_t mk(input bit we, input int addr, input int data);
    txn_t t;
    t.we    = we;
    t.addr  = AW'(addr);
    t.wdata = DW'(data);
    return t;
  endfunction

  initial begin
    int na, nb, guard;
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_last_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    rst_n = 1'b1;

    // Single write, then read-back
    qa.push_back(mk(1'b1, 9, 45));
    run_batch(1'b0);
    qa.push_back(mk(1'b0, 9, 0));
    run_batch(1'b0);

    // Tie of two writes, then read both back
    qa.push_back(mk(1'b1, 29, 54));
    qb.push_back(mk(1'b1, 1, 40));
    run_batch(1'b0);
    qa.push_back(mk(1'b0, 29, 0));
    qb.push_back(mk(1'b0, 1, 0));
    run_batch(1'b0);

    // Continuous requests from both ports
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mk(1'b1, 40 + i, 16 + i));
      qb.push_back(mk(1'b0, 40 + i, 0));
    end
    run_batch(1'b0);

    // Reset in the middle of a B write to addr 13
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'd13; b_wdata = 8'hA5;
    @(negedge clk);
    check("s5_mem_en_pre", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    check("s5_mem_en", 32'(mem_en), 32'd0);
    check("s5_mem_w_en", 32'(mem_w_en), 32'd0);
    check("s5_mem_addr", 32'(mem_addr), 32'd0);
    check("s5_mem_wdata", 32'(mem_wdata), 32'd0);
    check("s5_a_rdata", 32'(a_rdata), 32'd0);
    check("s5_b_rdata", 32'(b_rdata), 32'd0);
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_last_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("s5_b_ack", 32'(b_ack), 32'd0);
    end
    rst_n = 1'b1;
    qb.push_back(mk(1'b0, 13, 0));
    run_batch(1'b0);

    // Address change during ACCESS must not disturb the read of addr 15
    qa.push_back(mk(1'b1, 15, 8'h77));
    run_batch(1'b0);
    qa.push_back(mk(1'b0, 15, 0));
    run_batch(1'b1);

    // Randomized batches over a small address window
    for (int i = 0; i < 40; i++) begin
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na == 0 && nb == 0) na = 1;
      for (int j = 0; j < na; j++)
        qa.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255))));
      for (int j = 0; j < nb; j++)
        qb.push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255))));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_batch(1'b0);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
